// File: rtl/icache_req_arb.sv
// rtl/icache_req_arb.sv - three-way request arbiter with registered output for icache lookup

package toy_pack;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  tid;
  } pc_req_t;

  localparam logic [1:0] SRC_DMD  = 2'd0;
  localparam logic [1:0] SRC_PREF = 2'd1;
  localparam logic [1:0] SRC_SNP  = 2'd2;

endpackage

module icache_req_arb
  import toy_pack::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             snp_vld,
  output logic             snp_rdy,
  input  pc_req_t          snp_pld,
  input  logic             dmd_vld,
  output logic             dmd_rdy,
  input  pc_req_t          dmd_pld,
  input  logic             pref_vld,
  output logic             pref_rdy,
  input  pc_req_t          pref_pld,
  input  logic             prefetch_enable,
  output logic             out_vld,
  input  logic             out_rdy,
  output pc_req_t          out_pld,
  output logic [1:0]       out_src,
  output logic [CNT_W-1:0] starve_cnt
);

  logic             out_vld_q, out_vld_d;
  pc_req_t          out_pld_q, out_pld_d;
  logic [1:0]       out_src_q, out_src_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  logic load_en;
  logic pref_act;
  logic pref_force;
  logic pref_drop;
  logic snp_gnt, dmd_gnt, pref_gnt;

  // The output slot can take a new request when empty or being drained this cycle.
  assign load_en    = !out_vld_q | out_rdy;
  assign pref_act   = pref_vld & prefetch_enable;
  assign pref_force = pref_act & (starve_q == CNT_W'(STARVE_MAX));
  assign pref_drop  = pref_vld & !prefetch_enable;

  // Fixed priority: snoop, starved prefetch, demand, prefetch.
  always_comb begin
    snp_gnt  = 1'b0;
    dmd_gnt  = 1'b0;
    pref_gnt = 1'b0;
    if (load_en) begin
      if (snp_vld) begin
        snp_gnt = 1'b1;
      end else if (pref_force) begin
        pref_gnt = 1'b1;
      end else if (dmd_vld) begin
        dmd_gnt = 1'b1;
      end else if (pref_act) begin
        pref_gnt = 1'b1;
      end
    end
  end

  // Disabled prefetches are acknowledged and dropped even while the slot is held.
  assign snp_rdy  = snp_gnt;
  assign dmd_rdy  = dmd_gnt;
  assign pref_rdy = pref_gnt | pref_drop;

  // Output register next state: reload on any grant, otherwise hold or empty.
  always_comb begin
    out_vld_d = out_vld_q;
    out_pld_d = out_pld_q;
    out_src_d = out_src_q;
    if (load_en) begin
      out_vld_d = snp_gnt | dmd_gnt | pref_gnt;
      if (snp_gnt) begin
        out_pld_d = snp_pld;
        out_src_d = SRC_SNP;
      end else if (pref_gnt) begin
        out_pld_d = pref_pld;
        out_src_d = SRC_PREF;
      end else if (dmd_gnt) begin
        out_pld_d = dmd_pld;
        out_src_d = SRC_DMD;
      end
    end
  end

  // Starvation counter: counts consecutive demand wins over a waiting prefetch.
  always_comb begin
    starve_d = starve_q;
    if (!pref_act) begin
      starve_d = '0;
    end else if (pref_gnt) begin
      starve_d = '0;
    end else if (dmd_gnt && (starve_q != CNT_W'(STARVE_MAX))) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // State registers; reset acts as a global flush of the in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      out_pld_q <= '0;
      out_src_q <= 2'd0;
      starve_q  <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      out_pld_q <= out_pld_d;
      out_src_q <= out_src_d;
      starve_q  <= starve_d;
    end
  end

  assign out_vld    = out_vld_q;
  assign out_pld    = out_pld_q;
  assign out_src    = out_src_q;
  assign starve_cnt = starve_q;

endmodule

// File: tb/tb_icache_req_arb.sv
// tb/tb_icache_req_arb.sv - scoreboard bench for icache_req_arb

module tb_icache_req_arb;
  import toy_pack::*;

  localparam int SM  = 4;
  localparam int CW  = $clog2(SM + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          snp_vld, snp_rdy;
  pc_req_t       snp_pld;
  logic          dmd_vld, dmd_rdy;
  pc_req_t       dmd_pld;
  logic          pref_vld, pref_rdy;
  pc_req_t       pref_pld;
  logic          prefetch_enable;
  logic          out_vld, out_rdy;
  pc_req_t       out_pld;
  logic [1:0]    out_src;
  logic [CW-1:0] starve_cnt;

  icache_req_arb #(.STARVE_MAX(SM)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .snp_vld         (snp_vld),
    .snp_rdy         (snp_rdy),
    .snp_pld         (snp_pld),
    .dmd_vld         (dmd_vld),
    .dmd_rdy         (dmd_rdy),
    .dmd_pld         (dmd_pld),
    .pref_vld        (pref_vld),
    .pref_rdy        (pref_rdy),
    .pref_pld        (pref_pld),
    .prefetch_enable (prefetch_enable),
    .out_vld         (out_vld),
    .out_rdy         (out_rdy),
    .out_pld         (out_pld),
    .out_src         (out_src),
    .starve_cnt      (starve_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    pc_req_t    pld;
    logic [1:0] src;
  } exp_t;

  exp_t sb_q[$];
  logic exp_vld;
  int   exp_cnt;
  int   checks   = 0;
  int   failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic pc_req_t mk(input logic [3:0] tid);
    pc_req_t r;
    r.pc  = $urandom;
    r.tid = tid;
    return r;
  endfunction

  task automatic clear_inputs();
    snp_vld         = 1'b0;
    dmd_vld         = 1'b0;
    pref_vld        = 1'b0;
    prefetch_enable = 1'b1;
    out_rdy         = 1'b1;
    snp_pld         = mk(4'h2);
    dmd_pld         = mk(4'h0);
    pref_pld        = mk(4'h1);
  endtask

  // One clock: check combinational/registered outputs against the model, then advance the model.
  task automatic step();
    exp_t e;
    logic load, pact, force_p;
    int   g;
    @(negedge clk);
    load    = !exp_vld || out_rdy;
    pact    = pref_vld && prefetch_enable;
    force_p = pact && (exp_cnt == SM);
    g = -1;
    if (load) begin
      if (snp_vld)      g = 2;
      else if (force_p) g = 1;
      else if (dmd_vld) g = 0;
      else if (pact)    g = 1;
    end
    check_eq("snp_rdy", snp_rdy, g == 2);
    check_eq("dmd_rdy", dmd_rdy, g == 0);
    check_eq("pref_rdy", pref_rdy, (g == 1) || (pref_vld && !prefetch_enable));
    check_eq("starve_cnt", starve_cnt, exp_cnt);
    check_eq("out_vld", out_vld, exp_vld);
    if (exp_vld && sb_q.size() > 0) begin
      e = sb_q[0];
      check_eq("out_pld", out_pld, e.pld);
      check_eq("out_src", out_src, e.src);
      if (out_rdy) begin
        void'(sb_q.pop_front());
        exp_vld = 1'b0;
      end
    end
    if (g >= 0) begin
      e.src = 2'(g);
      e.pld = (g == 2) ? snp_pld : (g == 1) ? pref_pld : dmd_pld;
      sb_q.push_back(e);
      exp_vld = 1'b1;
    end
    if (!pact)                   exp_cnt = 0;
    else if (g == 1)             exp_cnt = 0;
    else if (g == 0 && exp_cnt < SM) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    snp_vld         = 1'($urandom_range(0, 1));
    dmd_vld         = 1'($urandom_range(0, 1));
    pref_vld        = 1'($urandom_range(0, 1));
    prefetch_enable = 1'($urandom_range(0, 1));
    out_rdy         = 1'($urandom_range(0, 1));
    snp_pld         = mk(4'h2);
    dmd_pld         = mk(4'h0);
    pref_pld        = mk(4'h1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_vld", out_vld, 0);
    clear_inputs();
    rst_n   = 1'b1;
    exp_vld = 1'b0;
    exp_cnt = 0;
    sb_q.delete();
  endtask

  int   src_obs[10];
  int   cnt_obs[10];
  int   src_exp[10];
  int   cnt_exp[10];
  int   vld_cycles;
  pc_req_t held_a, new_b;

  initial begin
    src_exp = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    cnt_exp = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};

    // Reset then idle
    do_reset();
    check_eq("rst_out_pld", out_pld, 0);
    check_eq("rst_out_src", out_src, 0);
    check_eq("rst_starve", starve_cnt, 0);
    repeat (2) step();

    // Snoop priority over demand and prefetch
    for (int i = 0; i < 3; i++) begin
      snp_vld = 1'b1; dmd_vld = 1'b1; pref_vld = 1'b1;
      snp_pld = mk(4'h2); dmd_pld = mk(4'h0); pref_pld = mk(4'h1);
      step();
      check_eq("snp_prio_src", out_src, 2);
    end
    clear_inputs();
    step();

    // Starvation guard
    for (int i = 0; i < 10; i++) begin
      dmd_vld = 1'b1; pref_vld = 1'b1;
      dmd_pld = mk(4'h0); pref_pld = mk(4'h1);
      step();
      src_obs[i] = int'(out_src);
      cnt_obs[i] = int'(starve_cnt);
    end
    for (int i = 0; i < 10; i++) begin
      check_eq($sformatf("starve_src[%0d]", i), src_obs[i], src_exp[i]);
      check_eq($sformatf("starve_cnt[%0d]", i), cnt_obs[i], cnt_exp[i]);
    end
    clear_inputs();
    step();

    // Back-pressure with a pending demand
    held_a  = mk(4'hA);
    dmd_vld = 1'b1; dmd_pld = held_a; out_rdy = 1'b1;
    step();
    new_b   = mk(4'hB);
    dmd_pld = new_b; out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bp_hold_pld", out_pld, held_a);
    end
    out_rdy = 1'b1;
    step();
    check_eq("bp_new_pld", out_pld, new_b);
    clear_inputs();
    step();

    // Prefetch disabled: discarded, never loaded
    prefetch_enable = 1'b0; pref_vld = 1'b1; out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pref_pld = mk(4'h1);
      step();
    end
    clear_inputs();
    step();

    // Prefetch enable falls while a prefetch is registered: still delivered
    pref_vld = 1'b1; pref_pld = mk(4'h1); out_rdy = 1'b0;
    step();
    prefetch_enable = 1'b0;
    repeat (2) begin
      pref_pld = mk(4'h1);
      step();
    end
    pref_vld = 1'b0; out_rdy = 1'b1;
    step();
    clear_inputs();
    step();

    // Streaming: 16 back-to-back demands without bubbles
    vld_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      dmd_vld = 1'b1; dmd_pld = mk(4'(i));
      step();
      if (out_vld) vld_cycles++;
    end
    check_eq("stream_vld_cycles", vld_cycles, 16);
    clear_inputs();
    step();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      snp_vld         = ($urandom_range(0, 7) == 0);
      dmd_vld         = 1'($urandom_range(0, 1));
      pref_vld        = 1'($urandom_range(0, 1));
      prefetch_enable = ($urandom_range(0, 7) != 0);
      out_rdy         = ($urandom_range(0, 3) != 0);
      snp_pld  = mk(4'h2);
      dmd_pld  = mk(4'h0);
      pref_pld = mk(4'h1);
      step();
    end

    // Asynchronous reset mid-operation flushes the in-flight request
    clear_inputs();
    dmd_vld = 1'b1; dmd_pld = mk(4'hC); out_rdy = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_vld", out_vld, 0);
    check_eq("async_rst_cnt", starve_cnt, 0);
    do_reset();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
